seq_divider32: RTL and testbench

SEQ_DIVIDER32 -- requirements
Module: seq_divider32

---
 rtl/div_pkg.sv | 20 ++
 rtl/div_step.sv | 20 ++
 rtl/seq_divider32.sv | 113 +++++++++++
 tb/tb_seq_divider32.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared constants and types for the sequential restoring divider.
// Default operand width, FSM state encoding and the iteration counter width.
package div_pkg;

    localparam int unsigned DivWidth = 32;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StCalc = 2'd1,
        StDone = 2'd2
    } div_state_e;

    // One extra bit so the counter can hold WIDTH itself without wrapping.
    function automatic int unsigned div_cnt_width(input int unsigned width);
        return $clog2(width) + 1;
    endfunction

    localparam int unsigned DivCntWidth = div_cnt_width(DivWidth);

endpackage

// File: rtl/div_step.sv
// One restoring-division step: compare the shifted partial remainder with the divisor
// and subtract when it fits, producing the next remainder and one quotient bit.
module div_step
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DivWidth
) (
    input  logic [WIDTH:0]   rem_shift,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic             q_bit
);

    always_comb begin
        q_bit    = (rem_shift >= {1'b0, divisor});
        // The true difference is below the divisor, so a WIDTH-bit subtraction is exact.
        rem_next = rem_shift[WIDTH-1:0] - (q_bit ? divisor : '0);
    end

endmodule

// File: rtl/seq_divider32.sv
// Sequential unsigned divider: one restoring step per clock, WIDTH steps per division.
// A zero divisor skips the iteration and reports all-ones quotient with div_by_zero set.
module seq_divider32
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DivWidth
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic [WIDTH-1:0] Quotient,
    output logic [WIDTH-1:0] Remainder,
    output logic             Result_Valid,
    output logic             busy,
    output logic             div_by_zero
);

    localparam int unsigned           CntWidth = div_cnt_width(WIDTH);
    localparam logic [CntWidth-1:0]   LastStep = CntWidth'(WIDTH - 1);

    div_state_e          state_q, state_d;
    logic [CntWidth-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]    divisor_q, divisor_d;
    logic [WIDTH-1:0]    quo_d, rem_d;
    logic                valid_d, dbz_d;

    logic [WIDTH:0]      rem_shift;
    logic [WIDTH-1:0]    step_rem;
    logic                step_qbit;

    // Left shift of {Remainder, Quotient}: the dividend MSB enters the remainder.
    assign rem_shift = {Remainder, Quotient[WIDTH-1]};

    div_step #(
        .WIDTH(WIDTH)
    ) u_div_step (
        .rem_shift(rem_shift),
        .divisor  (divisor_q),
        .rem_next (step_rem),
        .q_bit    (step_qbit)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        divisor_d = divisor_q;
        quo_d     = Quotient;
        rem_d     = Remainder;
        dbz_d     = div_by_zero;
        valid_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    cnt_d = '0;
                    if (in_b != '0) begin
                        divisor_d = in_b;
                        quo_d     = in_a;
                        rem_d     = '0;
                        dbz_d     = 1'b0;
                        state_d   = StCalc;
                    end else begin
                        quo_d   = '1;
                        rem_d   = in_a;
                        dbz_d   = 1'b1;
                        state_d = StDone;
                    end
                end
            end
            StCalc: begin
                quo_d = {Quotient[WIDTH-2:0], step_qbit};
                rem_d = step_rem;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LastStep) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                // The pulse lands in the following cycle, back in idle.
                valid_d = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            divisor_q    <= '0;
            Quotient     <= '0;
            Remainder    <= '0;
            Result_Valid <= 1'b0;
            div_by_zero  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            divisor_q    <= divisor_d;
            Quotient     <= quo_d;
            Remainder    <= rem_d;
            Result_Valid <= valid_d;
            div_by_zero  <= dbz_d;
        end
    end

    assign busy = (state_q != StIdle);

endmodule

// File: tb/tb_seq_divider32.sv
// Self-checking bench for seq_divider32: arithmetic reference model checked every cycle,
// directed cases with literal expectations, and 1000 randomized divisions.
module tb_seq_divider32;

    localparam int unsigned W = 32;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic          start = 1'b0;
    logic [W-1:0]  in_a = '0;
    logic [W-1:0]  in_b = '0;
    logic [W-1:0]  Quotient;
    logic [W-1:0]  Remainder;
    logic          Result_Valid;
    logic          busy;
    logic          div_by_zero;

    int n_pass  = 0;
    int n_total = 0;

    seq_divider32 #(
        .WIDTH(W)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .start       (start),
        .in_a        (in_a),
        .in_b        (in_b),
        .Quotient    (Quotient),
        .Remainder   (Remainder),
        .Result_Valid(Result_Valid),
        .busy        (busy),
        .div_by_zero (div_by_zero)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: result by plain division; cycles_left counts down to the valid pulse.
    int           m_left  = 0;
    logic         m_valid = 1'b0;
    logic [W-1:0] m_q     = '0;
    logic [W-1:0] m_r     = '0;
    logic         m_dbz   = 1'b0;

    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            m_left  <= 0;
            m_valid <= 1'b0;
            m_q     <= '0;
            m_r     <= '0;
            m_dbz   <= 1'b0;
        end else if (m_left > 0) begin
            m_left  <= m_left - 1;
            m_valid <= (m_left == 1);
        end else begin
            m_valid <= 1'b0;
            if (start) begin
                if (in_b == '0) begin
                    m_q    <= '1;
                    m_r    <= in_a;
                    m_dbz  <= 1'b1;
                    m_left <= 1;
                end else begin
                    m_q    <= in_a / in_b;
                    m_r    <= in_a % in_b;
                    m_dbz  <= 1'b0;
                    m_left <= W + 1;
                end
            end
        end
    end

    always @(negedge CLK) begin
        chk("model valid", 64'(Result_Valid), 64'(m_valid));
        chk("model busy", 64'(busy), 64'(m_left != 0));
        if (m_left == 0) begin
            chk("model quotient", 64'(Quotient), 64'(m_q));
            chk("model remainder", 64'(Remainder), 64'(m_r));
            chk("model div_by_zero", 64'(div_by_zero), 64'(m_dbz));
        end
    end

    // Issue one division and wait (bounded) for its valid pulse; inj_at injects a 50/3 start.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] eq, input logic [W-1:0] er, input logic edbz,
                         input int elat, input int inj_at, input string tag);
        int   n;
        logic seen;
        @(posedge CLK);
        #1;
        start = 1'b1;
        in_a  = a;
        in_b  = b;
        @(posedge CLK);
        #1;
        start = 1'b0;
        in_a  = $urandom;
        in_b  = $urandom;
        n     = 0;
        seen  = 1'b0;
        while (!seen && n < 100) begin
            @(posedge CLK);
            n++;
            #1;
            if (Result_Valid) begin
                seen  = 1'b1;
                start = 1'b0;
            end else if (n == inj_at) begin
                start = 1'b1;
                in_a  = 32'd50;
                in_b  = 32'd3;
            end else begin
                start = 1'b0;
                in_a  = $urandom;
                in_b  = $urandom;
            end
        end
        chk({tag, " latency"}, 64'(n), 64'(elat));
        chk({tag, " quotient"}, 64'(Quotient), 64'(eq));
        chk({tag, " remainder"}, 64'(Remainder), 64'(er));
        chk({tag, " div_by_zero"}, 64'(div_by_zero), 64'(edbz));
        if (b != '0) begin
            chk({tag, " identity"}, 64'(Quotient) * 64'(b) + 64'(Remainder), 64'(a));
            chk({tag, " rem<b"}, 64'(Remainder < b), 64'd1);
        end
    endtask

    task automatic expect_quiet(input int cycles, input string tag);
        int cnt;
        cnt = 0;
        repeat (cycles) begin
            @(posedge CLK);
            #1;
            if (Result_Valid) cnt++;
        end
        chk({tag, " extra valid"}, 64'(cnt), 64'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] a;
        logic [W-1:0] b;
        int           sel;

        RST = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        chk("reset quotient", 64'(Quotient), 64'd0);
        chk("reset remainder", 64'(Remainder), 64'd0);
        chk("reset valid", 64'(Result_Valid), 64'd0);
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset div_by_zero", 64'(div_by_zero), 64'd0);
        RST = 1'b1;

        do_op(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33, -1, "100/7");
        do_op(32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 33, -1, "max/1");
        do_op(32'd3, 32'd10, 32'd0, 32'd3, 1'b0, 33, -1, "3/10");
        do_op(32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1, 1, -1, "5/0");

        do_op(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33, 10, "start in calc");
        expect_quiet(40, "start in calc");
        do_op(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33, 32, "start in done");
        expect_quiet(40, "start in done");

        // Abort a running division with an asynchronous reset in CALC cycle 15.
        @(posedge CLK);
        #1;
        start = 1'b1;
        in_a  = 32'd100;
        in_b  = 32'd7;
        @(posedge CLK);
        #1;
        start = 1'b0;
        repeat (15) @(posedge CLK);
        #3;
        RST = 1'b0;
        #1;
        chk("abort quotient", 64'(Quotient), 64'd0);
        chk("abort remainder", 64'(Remainder), 64'd0);
        chk("abort valid", 64'(Result_Valid), 64'd0);
        chk("abort busy", 64'(busy), 64'd0);
        chk("abort div_by_zero", 64'(div_by_zero), 64'd0);
        @(posedge CLK);
        #3;
        RST = 1'b1;
        expect_quiet(40, "abort");
        do_op(32'd81, 32'd9, 32'd9, 32'd0, 1'b0, 33, -1, "81/9");

        for (int i = 0; i < 1000; i++) begin
            sel = int'($urandom_range(0, 9));
            a   = (sel == 9) ? W'($urandom_range(0, 1000)) : W'($urandom);
            if (sel == 0) begin
                b = '0;
            end else if (sel < 4) begin
                b = W'($urandom_range(1, 255));
            end else if (sel < 7) begin
                b = W'($urandom) >> $urandom_range(0, 31);
            end else begin
                b = W'($urandom);
            end
            repeat ($urandom_range(0, 2)) @(posedge CLK);
            if (b == '0) begin
                do_op(a, b, '1, a, 1'b1, 1, -1, "random");
            end else begin
                do_op(a, b, a / b, a % b, 1'b0, 33, -1, "random");
            end
        end

        repeat (2) @(posedge CLK);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
